rr_src4_4b: RTL and testbench

- Four-channel, 4-bit source sequencer that sits directly upstream of the 4:1 4-bit multiplexer stage.
- Buffers one nibble per channel, presented on i0..i3.
- Round-robin arbiter drives select lines s1,s0 so the mux output f carries the granted channel.
- Valid/ready handshake to the downstream consumer of f; counts completed transfers.

---
 rtl/rr_src4_4b.sv | 142 ++++++++++++++
 tb/tb_rr_src4_4b.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_src4_4b.sv
// rr_src4_4b: four-channel nibble source sequencer feeding a 4:1 4-bit mux.
// Each channel has a one-deep holding register; a round-robin arbiter picks a
// full channel, drives the mux selects and hands the nibble downstream over a
// valid/ready handshake, counting completed transfers.
module rr_src4_4b #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  input  logic [3:0]       d0,
  input  logic [3:0]       d1,
  input  logic [3:0]       d2,
  input  logic [3:0]       d3,
  output logic [3:0]       in_ready,
  output logic [3:0]       i0,
  output logic [3:0]       i1,
  output logic [3:0]       i2,
  output logic [3:0]       i3,
  output logic             s0,
  output logic             s1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [3:0]       full_q, full_d;
  logic [3:0]       i0_q, i0_d;
  logic [3:0]       i1_q, i1_d;
  logic [3:0]       i2_q, i2_d;
  logic [3:0]       i3_q, i3_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]       cap;
  logic [3:0]       clr;

  // First set request scanning start, start+1, ... modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] res;
    logic       found;
    res   = start;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = start + k[1:0];
      if (!found && req[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Capture into empty holding registers only; a full channel ignores writes.
  always_comb begin
    cap  = in_valid & ~full_q;
    i0_d = cap[0] ? d0 : i0_q;
    i1_d = cap[1] ? d1 : i1_q;
    i2_d = cap[2] ? d2 : i2_q;
    i3_d = cap[3] ? d3 : i3_q;
  end

  // Arbiter FSM: pick from registered full bits in IDLE, hold the grant until accepted.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    clr         = 4'b0000;
    case (state_q)
      IDLE: begin
        out_valid_d = 1'b0;
        if (|full_q) begin
          sel_d       = rr_pick(full_q, ptr_q);
          out_valid_d = 1'b1;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        out_valid_d = 1'b1;
        if (out_ready) begin
          clr[sel_q]  = 1'b1;
          ptr_d       = sel_q + 2'd1;
          cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    // The granted channel is full, so it never captures in the same cycle it clears.
    full_d = (full_q | cap) & ~clr;
  end

  // State, data and counter registers; reset discards any pending grant and data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      full_q      <= 4'b0000;
      i0_q        <= 4'h0;
      i1_q        <= 4'h0;
      i2_q        <= 4'h0;
      i3_q        <= 4'h0;
      sel_q       <= 2'b00;
      ptr_q       <= 2'b00;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      i0_q        <= i0_d;
      i1_q        <= i1_d;
      i2_q        <= i2_d;
      i3_q        <= i3_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = ~full_q;
  assign i0        = i0_q;
  assign i1        = i1_q;
  assign i2        = i2_q;
  assign i3        = i3_q;
  assign s0        = sel_q[0];
  assign s1        = sel_q[1];
  assign out_valid = out_valid_q;
  assign cnt       = cnt_q;

endmodule

// File: tb/tb_rr_src4_4b.sv
// Testbench for rr_src4_4b: scoreboard of expected (channel, nibble) grants,
// checked whenever a transfer completes, plus directed checks.
module tb_rr_src4_4b;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] in_valid = 4'b0;
  logic [3:0] d0 = 4'h0, d1 = 4'h0, d2 = 4'h0, d3 = 4'h0;
  logic [3:0] in_ready;
  logic [3:0] i0, i1, i2, i3;
  logic       s0, s1, out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] cnt;

  // Second instance with a narrow counter for wrap checks.
  logic [3:0] in_valid2 = 4'b0;
  logic [3:0] b_d0 = 4'h0;
  logic [3:0] in_ready2, j0, j1, j2, j3;
  logic       t0, t1, out_valid2;
  logic       out_ready2 = 1'b1;
  logic [1:0] cnt2;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_hs = -1;
  int exp_cnt = 0;
  logic gap_chk = 1'b0;

  typedef struct packed {
    logic [1:0] ch;
    logic [3:0] data;
  } xfer_t;
  xfer_t sb[$];

  rr_src4_4b #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .in_ready(in_ready), .i0(i0), .i1(i1), .i2(i2), .i3(i3),
    .s0(s0), .s1(s1), .out_valid(out_valid), .out_ready(out_ready), .cnt(cnt)
  );

  rr_src4_4b #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2),
    .d0(b_d0), .d1(4'h0), .d2(4'h0), .d3(4'h0),
    .in_ready(in_ready2), .i0(j0), .i1(j1), .i2(j2), .i3(j3),
    .s0(t0), .s1(t1), .out_valid(out_valid2), .out_ready(out_ready2), .cnt(cnt2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Downstream 4:1 mux as it sits after this block.
  function automatic logic [3:0] mux_f();
    case ({s1, s0})
      2'd0: return i0;
      2'd1: return i1;
      2'd2: return i2;
      default: return i3;
    endcase
  endfunction

  // Transfer monitor: compares every completed handshake against the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_xfer", 1, 0);
      end else begin
        xfer_t e;
        e = sb.pop_front();
        check("grant_sel", int'({s1, s0}), int'(e.ch));
        check("grant_f", int'(mux_f()), int'(e.data));
        check("cnt_at_xfer", int'(cnt), exp_cnt % 256);
      end
      exp_cnt++;
      if (gap_chk && last_hs >= 0) check("xfer_gap", cyc - last_hs, 2);
      last_hs = cyc;
    end
    if (!gap_chk) last_hs = -1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      if (sb.size() == 0 && !out_valid) break;
      step();
    end
    check("drain_empty", sb.size(), 0);
    check("drain_idle", int'(out_valid), 0);
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    #1;
    check("rst_in_ready", int'(in_ready), 4'hF);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_sel", int'({s1, s0}), 0);
    check("rst_cnt", int'(cnt), 0);
    check("rst_data", int'({i3, i2, i1, i0}), 0);
    sb.delete();
    exp_cnt = 0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Test 1: single channel 2 transfer.
    do_reset();
    check("rst_cnt2", int'(cnt2), 0);
    out_ready = 1'b1;
    in_valid = 4'b0100; d2 = 4'hA;
    sb.push_back('{ch: 2'd2, data: 4'hA});
    step();
    in_valid = 4'b0;
    check("t1_in_ready", int'(in_ready), 4'b1011);
    check("t1_ov_idle", int'(out_valid), 0);
    step();
    check("t1_ov", int'(out_valid), 1);
    check("t1_sel", int'({s1, s0}), 2);
    check("t1_i2", int'(i2), 4'hA);
    step();
    check("t1_ov_done", int'(out_valid), 0);
    check("t1_in_ready_done", int'(in_ready), 4'hF);
    check("t1_cnt", int'(cnt), 1);

    // Test 2: all four channels at once, served 0,1,2,3 one per two cycles.
    do_reset();
    out_ready = 1'b1;
    gap_chk = 1'b1;
    in_valid = 4'b1111; d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
    for (int c = 0; c < 4; c++) sb.push_back('{ch: 2'(c), data: 4'(c + 1)});
    step();
    in_valid = 4'b0;
    drain();
    gap_chk = 1'b0;
    check("t2_cnt", int'(cnt), 4);

    // Test 3: serve channel 1 (pointer moves to 2), then 3 wins over 0.
    in_valid = 4'b0010; d1 = 4'h7;
    sb.push_back('{ch: 2'd1, data: 4'h7});
    step();
    in_valid = 4'b0;
    drain();
    in_valid = 4'b1001; d0 = 4'h8; d3 = 4'h9;
    sb.push_back('{ch: 2'd3, data: 4'h9});
    sb.push_back('{ch: 2'd0, data: 4'h8});
    step();
    in_valid = 4'b0;
    drain();
    check("t3_cnt", int'(cnt), 7);

    // Test 4: backpressure on channel 0 with a write attempt to the full channel.
    out_ready = 1'b0;
    in_valid = 4'b0001; d0 = 4'h5;
    sb.push_back('{ch: 2'd0, data: 4'h5});
    step();
    in_valid = 4'b0;
    step();
    for (int c = 0; c < 5; c++) begin
      in_valid = 4'b0001; d0 = 4'h9;
      step();
      check("t4_ov", int'(out_valid), 1);
      check("t4_sel", int'({s1, s0}), 0);
      check("t4_i0", int'(i0), 4'h5);
      check("t4_rdy0", int'(in_ready[0]), 0);
    end
    in_valid = 4'b0;
    out_ready = 1'b1;
    drain();
    check("t4_cnt", int'(cnt), 8);

    // Test 5: reset while granting with channels 1 and 2 full.
    out_ready = 1'b0;
    in_valid = 4'b0110; d1 = 4'h3; d2 = 4'h4;
    step();
    in_valid = 4'b0;
    step();
    check("t5_ov_pre", int'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("t5_ov", int'(out_valid), 0);
    check("t5_in_ready", int'(in_ready), 4'hF);
    check("t5_cnt", int'(cnt), 0);
    check("t5_sel", int'({s1, s0}), 0);
    check("t5_data", int'({i3, i2, i1, i0}), 0);
    sb.delete();
    exp_cnt = 0;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("t5_no_grant", int'(out_valid), 0);
    end
    in_valid = 4'b0100; d2 = 4'h6;
    sb.push_back('{ch: 2'd2, data: 4'h6});
    step();
    in_valid = 4'b0;
    drain();
    check("t5_cnt_after", int'(cnt), 1);

    // Test 6: two-bit counter wraps 1,2,3,0,1.
    for (int k = 0; k < 5; k++) begin
      in_valid2 = 4'b0001; b_d0 = 4'(k + 1);
      step();
      in_valid2 = 4'b0;
      step();
      check("t6_ov", int'(out_valid2), 1);
      check("t6_i0", int'(j0), k + 1);
      step();
      check("t6_cnt2", int'(cnt2), (k + 1) % 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
